// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared pipeline constants (opcodes, NOP, register indices) for fetch/decode/execute
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSN = 32'h0000_0000;

    localparam logic [4:0] OP_ALU = 5'b00000;
    localparam logic [4:0] OP_J   = 5'b00001;
    localparam logic [4:0] OP_BNE = 5'b00010;
    localparam logic [4:0] OP_JAL = 5'b00011;
    localparam logic [4:0] OP_JR  = 5'b00100;
    localparam logic [4:0] OP_BLT = 5'b00110;
    localparam logic [4:0] OP_BEX = 5'b10110;

    localparam logic [4:0] R_STATUS = 5'd30;
    localparam logic [4:0] R_31     = 5'd31;

    // Unsigned increment; wraps from all-ones to zero with no carry out.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// rtl/fetch_stage_pc_reg.sv - 32-bit register with write enable and async active-low clear to RESET_VAL
module pc_reg #(
    parameter logic [31:0] RESET_VAL = 32'd0
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        en_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);

    logic [31:0] val_q;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            val_q <= RESET_VAL;
        end else if (en_i) begin
            val_q <= d_i;
        end
    end

    assign q_o = val_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, instruction fetch and F/D latch with decode/execute redirect squash
// Optional FETCH_PERF_EN adds perf_fetched/perf_squashed counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'd0,
    parameter int          IMEM_ADDR_WIDTH = 12,
    parameter logic [31:0] NOP             = NOP_INSN
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic [IMEM_ADDR_WIDTH-1:0] address_imem,
    input  logic [31:0]                q_imem,
    input  logic                       stall,
    input  logic                       dec_branch_taken,
    input  logic [31:0]                dec_PC_branch,
    input  logic                       exe_redirect,
    input  logic [31:0]                exe_PC_branch,
    output logic [31:0]                fd_instruction,
    output logic [31:0]                fd_PC_updated,
    output logic                       fd_valid,
`ifdef FETCH_PERF_EN
    output logic [31:0]                perf_fetched,
    output logic [31:0]                perf_squashed,
`endif
    output logic [31:0]                pc_out
);

    logic [31:0] pc_q, pc_d, pc_plus1;
    logic [31:0] fd_insn_d, fd_pcu_d;
    logic        fd_valid_q;
    logic        dec_take, squash, advance, fetch;

    assign pc_plus1 = pc_inc(pc_q);
    assign dec_take = dec_branch_taken & fd_valid_q & ~stall;
    assign squash   = exe_redirect | dec_take;
    assign fetch    = ~squash & ~stall;
    // Execute redirect overrides stall, so the pipeline advances on any squash.
    assign advance  = squash | ~stall;

    always_comb begin
        pc_d      = pc_plus1;
        fd_insn_d = q_imem;
        fd_pcu_d  = pc_plus1;
        if (exe_redirect) begin
            pc_d = exe_PC_branch;
        end else if (dec_take) begin
            pc_d = dec_PC_branch;
        end
        if (squash) begin
            fd_insn_d = NOP;
            fd_pcu_d  = 32'd0;
        end
    end

    pc_reg #(.RESET_VAL(RESET_PC)) u_pc (
        .clock_i(clock), .reset_i(reset), .en_i(advance), .d_i(pc_d), .q_o(pc_q)
    );

    pc_reg #(.RESET_VAL(NOP)) u_fd_insn (
        .clock_i(clock), .reset_i(reset), .en_i(advance), .d_i(fd_insn_d), .q_o(fd_instruction)
    );

    pc_reg #(.RESET_VAL(32'd0)) u_fd_pcu (
        .clock_i(clock), .reset_i(reset), .en_i(advance), .d_i(fd_pcu_d), .q_o(fd_PC_updated)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fd_valid_q <= 1'b0;
        end else if (advance) begin
            fd_valid_q <= fetch;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_squashed_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_fetched_q  <= 32'd0;
            perf_squashed_q <= 32'd0;
        end else begin
            if (fetch) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (squash && fd_valid_q) begin
                perf_squashed_q <= perf_squashed_q + 32'd1;
            end
        end
    end

    assign perf_fetched  = perf_fetched_q;
    assign perf_squashed = perf_squashed_q;
`endif

    assign fd_valid     = fd_valid_q;
    assign pc_out       = pc_q;
    assign address_imem = pc_q[IMEM_ADDR_WIDTH-1:0];

endmodule
